// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin requester-side scheduler:
// one-hot FSM state encoding and a one-hot check helper.
package rr_sched_pkg;

    localparam int unsigned StateW = 5;

    localparam logic [StateW-1:0] StIdle    = 5'b00001;
    localparam logic [StateW-1:0] StReq     = 5'b00010;
    localparam logic [StateW-1:0] StWaitGnt = 5'b00100;
    localparam logic [StateW-1:0] StSlot    = 5'b01000;
    localparam logic [StateW-1:0] StDone    = 5'b10000;

    // Callers zero-extend narrower vectors to 32 bits.
    function automatic logic is_onehot(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/rr_pending_vec.sv
// Per-channel pending register: set and clear pulses, set wins on the same
// cycle so a re-request during its own grant is never lost.
module rr_pending_vec #(
    parameter int unsigned P_WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [P_WIDTH-1:0] i_set,
    input  logic [P_WIDTH-1:0] i_clr,
    output logic [P_WIDTH-1:0] o_pending
);

    logic [P_WIDTH-1:0] pending_q;
    logic [P_WIDTH-1:0] pending_d;

    always_comb begin
        pending_d = (pending_q & ~i_clr) | i_set;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign o_pending = pending_q;

endmodule

// File: rtl/rr_req_scheduler.sv
// Requester-side companion to the round-robin arbiter: collects channel requests,
// hands a snapshot to the arbiter and drives a timed slot to the granted channel.
module rr_req_scheduler
    import rr_sched_pkg::*;
#(
    parameter int unsigned P_CHANNEL_NUM = 8,
    parameter int unsigned P_SLOT_CYCLES = 16,
    parameter int unsigned P_GNT_TIMEOUT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [P_CHANNEL_NUM-1:0] i_ch_req,
    input  logic                     i_epoch_start,
    output logic [P_CHANNEL_NUM-1:0] o_arb_req,
    output logic                     o_arb_req_valid,
    input  logic [P_CHANNEL_NUM-1:0] i_arb_grant,
    input  logic                     i_arb_grant_valid,
    output logic                     o_arb_reset_priority,
    output logic [P_CHANNEL_NUM-1:0] o_slot_grant,
    output logic                     o_slot_start,
    output logic [P_CHANNEL_NUM-1:0] o_slot_done,
    output logic [P_CHANNEL_NUM-1:0] o_pending,
    output logic                     o_err
);

    localparam int unsigned SlotCntW = $clog2(P_SLOT_CYCLES + 1);
    localparam int unsigned WaitCntW = $clog2(P_GNT_TIMEOUT + 1);

    logic [StateW-1:0]        state_q, state_d;
    logic [P_CHANNEL_NUM-1:0] arb_req_q, arb_req_d;
    logic [P_CHANNEL_NUM-1:0] owner_q, owner_d;
    logic [SlotCntW-1:0]      slot_cnt_q, slot_cnt_d;
    logic [WaitCntW-1:0]      wait_cnt_q, wait_cnt_d;
    logic                     err_q, err_d;
    logic                     rst_prio_q;

    logic [P_CHANNEL_NUM-1:0] pending;
    logic [P_CHANNEL_NUM-1:0] pend_clr;
    logic                     gnt_onehot;
    logic                     gnt_hits_req;

    rr_pending_vec #(
        .P_WIDTH (P_CHANNEL_NUM)
    ) u_pending (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_set     (i_ch_req),
        .i_clr     (pend_clr),
        .o_pending (pending)
    );

    assign gnt_onehot   = is_onehot(32'(i_arb_grant));
    assign gnt_hits_req = |(i_arb_grant & arb_req_q);

    always_comb begin
        state_d    = state_q;
        arb_req_d  = arb_req_q;
        owner_d    = owner_q;
        slot_cnt_d = slot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        pend_clr   = '0;

        case (state_q)
            StIdle: begin
                // Epoch start holds off the request so the priority reset lands first.
                if ((|pending) && !i_epoch_start) begin
                    state_d   = StReq;
                    arb_req_d = pending;
                end
            end
            StReq: begin
                state_d    = StWaitGnt;
                wait_cnt_d = '0;
            end
            StWaitGnt: begin
                if (i_arb_grant_valid) begin
                    if (i_arb_grant == '0) begin
                        state_d = StIdle;
                    end else if (gnt_onehot && gnt_hits_req) begin
                        state_d    = StSlot;
                        owner_d    = i_arb_grant;
                        pend_clr   = i_arb_grant;
                        slot_cnt_d = SlotCntW'(P_SLOT_CYCLES);
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end else if (wait_cnt_q == WaitCntW'(P_GNT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitCntW'(1);
                end
            end
            StSlot: begin
                slot_cnt_d = slot_cnt_q - SlotCntW'(1);
                if (slot_cnt_q == SlotCntW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            arb_req_q  <= '0;
            owner_q    <= '0;
            slot_cnt_q <= '0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            rst_prio_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            arb_req_q  <= arb_req_d;
            owner_q    <= owner_d;
            slot_cnt_q <= slot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            rst_prio_q <= i_epoch_start;
        end
    end

    // Outputs decode straight from flops, so an async reset clears them at once.
    assign o_arb_req            = arb_req_q;
    assign o_arb_req_valid      = (state_q == StReq);
    assign o_arb_reset_priority = rst_prio_q;
    assign o_slot_grant         = (state_q == StSlot) ? owner_q : '0;
    assign o_slot_start         = (state_q == StSlot) && (slot_cnt_q == SlotCntW'(P_SLOT_CYCLES));
    assign o_slot_done          = (state_q == StDone) ? owner_q : '0;
    assign o_pending            = pending;
    assign o_err                = err_q;

endmodule

// File: doc/rr_req_scheduler.md
Name: rr_req_scheduler

Overview:
- Requester-side companion to the round-robin arbiter in the optical 8x8 controller.
- Collects per-channel slot-request pulses into a pending vector and presents it to the arbiter as a req/req_valid pair.
- Consumes the registered one-hot grant, then drives a timed optical slot to the winning channel.
- Sits between the per-port request logic and the arbiter. Owns the pending state, the slot timing, and the arbiter's priority reset.

Parameters:
- P_CHANNEL_NUM, 8, number of channels; must match the arbiter; range 2..32.
- P_SLOT_CYCLES, 16, clock cycles a granted slot is held; must be >= 1.
- P_GNT_TIMEOUT, 4, cycles to wait for arb grant_valid after a request before declaring an error; must be >= 2.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_ch_req  in  P_CHANNEL_NUM  per-channel request pulses; one-cycle pulses, may overlap
- i_epoch_start  in  1  pulse; restart arbitration fairness
- o_arb_req  out  P_CHANNEL_NUM  request vector to arbiter i_req
- o_arb_req_valid  out  1  to arbiter i_req_valid
- i_arb_grant  in  P_CHANNEL_NUM  from arbiter o_grant
- i_arb_grant_valid  in  1  from arbiter o_grant_valid
- o_arb_reset_priority  out  1  to arbiter reset_priority
- o_slot_grant  out  P_CHANNEL_NUM  one-hot active slot owner, 0 when no slot
- o_slot_start  out  1  pulse, first cycle of slot
- o_slot_done  out  P_CHANNEL_NUM  one-hot pulse, cycle after last slot cycle
- o_pending  out  P_CHANNEL_NUM  current pending vector (status)
- o_err  out  1  sticky error; cleared only by reset

Behaviour:
- Reset (async, i_rst_n low): all outputs 0, pending 0, FSM IDLE, counters 0.
- Pending: pending[i] <= (pending[i] & ~clr[i]) | i_ch_req[i]. Set wins over same-cycle clear. A request while already pending merges; there is no count.
- FSM states: IDLE, REQ, WAIT_GNT, SLOT, DONE.
- IDLE: if pending != 0 and i_epoch_start = 0, go to REQ.
- REQ (1 cycle): o_arb_req_valid = 1 and o_arb_req = pending, registered from the IDLE-cycle pending. Then go to WAIT_GNT and clear the wait counter.
- o_arb_req holds its last value outside REQ. o_arb_req_valid is high only in REQ.
- WAIT_GNT: the arbiter's nominal latency is 1 cycle, so grant_valid is expected on the first WAIT_GNT cycle. Outcomes:
  - grant_valid with grant one-hot and grant & o_arb_req != 0: latch slot owner, clear that pending bit, go to SLOT.
  - grant_valid with grant == 0: return to IDLE, no error.
  - grant_valid with grant not one-hot, or not a subset of o_arb_req: set o_err, return to IDLE, pending unchanged.
  - no grant_valid after P_GNT_TIMEOUT cycles: set o_err, return to IDLE.
- SLOT: o_slot_grant = owner for exactly P_SLOT_CYCLES cycles. o_slot_start pulses on the first of them. Then go to DONE.
- DONE (1 cycle): o_slot_done = owner, o_slot_grant = 0. Then go to IDLE.
- Minimum request-to-request spacing is therefore IDLE+REQ+WAIT+SLOT+DONE = P_SLOT_CYCLES + 4.
- grant_valid arriving outside WAIT_GNT is ignored. It does not set an error; the arbiter rotates only on its own grant_valid.
- o_arb_reset_priority: registered copy of i_epoch_start (1-cycle pulse).
- Epoch start in IDLE blocks the REQ transition that cycle, so the arbiter priority reset takes effect before the next request.
- Epoch start in other states: no effect on the FSM; an in-flight slot completes.
- The slot counter is a $clog2(P_SLOT_CYCLES+1)-bit down-counter. No wrap is permitted.
- Reset mid-slot: o_slot_grant drops to 0 asynchronously. No o_slot_done is issued.

Decomposition:
- Shared package (rr_sched_pkg): FSM state encoding (localparam one-hot, 5 bits) and a onehot-check function usable by the arbiter bench.
- One sub-module is natural: rr_pending_vec, holding the per-channel set/clear pending register with set-priority. The FSM, counters and checks stay in the top.

Test Plan:
- Single request: pulse i_ch_req=8'h04. Required: o_arb_req=8'h04 with req_valid for 1 cycle; grant 8'h04 one cycle later; o_slot_grant=8'h04 for 16 cycles with o_slot_start; then o_slot_done=8'h04; o_pending returns to 0.
- All 8 channels request at once, with the real RR_arbiter connected. Required: slots granted in rotating order 8'h01, 8'h02 … 8'h80, each exactly 16 cycles; no o_err.
- Channel 2 re-requests in the same cycle its pending bit is cleared by grant. Required: o_pending[2] stays 1, and a second slot for channel 2 follows.
- Stub arbiter never asserts grant_valid. Required: o_err=1 after 4 WAIT_GNT cycles; FSM returns to IDLE; pending unchanged.
- Stub grant 8'h03 (not one-hot), then separately grant 8'h10 with req 8'h01 (not a subset). Required: o_err=1 in both runs; no slot issued.
- i_epoch_start in IDLE with pending != 0: o_arb_reset_priority pulses next cycle and REQ is delayed one cycle. Separately, i_rst_n low mid-slot: all outputs 0 immediately, and no o_slot_done after release.
